control_unit: RTL and testbench

Moore-style instruction sequencer that drives every control input of `datapath` from the instruction held in IR. It replaces hand-sequenced per-state stimulus with a hardware state machine. The machine runs fetch (T0–T2) and decode, then per-opcode execute steps (T3–T7), and loops until a `halt` instruction or `clear`. Each step lasts exactly one `clock` cycle, and the datapath acts on the asserted signals at the next rising edge.

---
 rtl/control_unit.sv | 181 ++++++++++++++++++
 tb/tb_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Moore instruction sequencer: fetch (T0-T2), then per-opcode execute steps (T3-T7),
// producing every datapath control strobe as a pure decode of state and opcode.
module control_unit #(
  parameter int OPW = 5
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] ir,
  output logic        pco,
  output logic        pci,
  output logic        incpc,
  output logic        iri,
  output logic        mari,
  output logic        mdri,
  output logic        mdro,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ryi,
  output logic        rzli,
  output logic        rzlo,
  output logic        rzhi,
  output logic        rzho,
  output logic        hio,
  output logic        loo,
  output logic        ipo,
  output logic        opi,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        baout,
  output logic        csigno,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
  localparam logic [OPW-1:0] OP_IN   = OPW'(5'b10110);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(5'b10111);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(5'b11000);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(5'b11001);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  state_t         state;
  state_t         state_next;
  logic [OPW-1:0] opcode;
  logic           is_rtype;
  logic           is_mem;
  logic           unused_ir;

  assign opcode    = ir[31 -: OPW];
  assign unused_ir = ^ir[31-OPW:0];
  assign is_rtype  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);
  assign is_mem    = (opcode == OP_LD) || (opcode == OP_ST);
  assign dbg_state = state;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_RESET;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_T0;
      S_T0:    state_next = S_T1;
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3: begin
        if (opcode == OP_HALT)
          state_next = S_HALT;
        else if (is_mem || is_rtype || opcode == OP_LDI || opcode == OP_ADDI)
          state_next = S_T4;
        else
          state_next = S_T0;
      end
      S_T4:    state_next = S_T5;
      S_T5:    state_next = is_mem ? S_T6 : S_T0;
      S_T6:    state_next = S_T7;
      S_T7:    state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_RESET;
    endcase
  end

  // Only one bus driver per step; unreachable opcode/step pairs decode to nothing.
  always_comb begin
    pco = 1'b0; pci = 1'b0; incpc = 1'b0; iri = 1'b0;
    mari = 1'b0; mdri = 1'b0; mdro = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    ryi = 1'b0; rzli = 1'b0; rzlo = 1'b0; rzhi = 1'b0; rzho = 1'b0;
    hio = 1'b0; loo = 1'b0; ipo = 1'b0; opi = 1'b0;
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
    baout = 1'b0; csigno = 1'b0;
    alu_op = ALU_ADD;
    run = (state >= S_T0) && (state <= S_T7);
    case (state)
      S_T0: begin pco = 1'b1; mari = 1'b1; incpc = 1'b1; end
      S_T1: begin mem_read = 1'b1; mdri = 1'b1; end
      S_T2: begin mdro = 1'b1; iri = 1'b1; end
      S_T3: begin
        if (is_mem || opcode == OP_LDI) begin
          grb = 1'b1; baout = 1'b1; ryi = 1'b1;
        end else if (is_rtype || opcode == OP_ADDI) begin
          grb = 1'b1; rout = 1'b1; ryi = 1'b1;
        end else if (opcode == OP_IN) begin
          ipo = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (opcode == OP_OUT) begin
          gra = 1'b1; rout = 1'b1; opi = 1'b1;
        end else if (opcode == OP_MFHI) begin
          hio = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (opcode == OP_MFLO) begin
          loo = 1'b1; gra = 1'b1; rin = 1'b1;
        end
      end
      S_T4: begin
        if (is_rtype) begin
          grc = 1'b1; rout = 1'b1; rzli = 1'b1;
          case (opcode)
            OP_SUB:  alu_op = ALU_SUB;
            OP_AND:  alu_op = ALU_AND;
            OP_OR:   alu_op = ALU_OR;
            default: alu_op = ALU_ADD;
          endcase
        end else if (is_mem || opcode == OP_LDI || opcode == OP_ADDI) begin
          csigno = 1'b1; rzli = 1'b1;
        end
      end
      S_T5: begin
        if (is_mem) begin
          rzlo = 1'b1; mari = 1'b1;
        end else if (is_rtype || opcode == OP_LDI || opcode == OP_ADDI) begin
          rzlo = 1'b1; gra = 1'b1; rin = 1'b1;
        end
      end
      S_T6: begin
        if (opcode == OP_LD) begin
          mem_read = 1'b1; mdri = 1'b1;
        end else if (opcode == OP_ST) begin
          gra = 1'b1; rout = 1'b1; mdri = 1'b1;
        end
      end
      S_T7: begin
        if (opcode == OP_LD) begin
          mdro = 1'b1; gra = 1'b1; rin = 1'b1;
        end else if (opcode == OP_ST) begin
          mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class step by step against
// hand-built control vectors and watches the single-bus-driver rule every cycle.
module tb_control_unit;

  logic        clock;
  logic        clear;
  logic [31:0] ir;
  logic pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write;
  logic ryi, rzli, rzlo, rzhi, rzho, hio, loo, ipo, opi;
  logic gra, grb, grc, rin, rout, baout, csigno, run;
  logic [3:0] alu_op;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [29:0] M_PCO   = 30'd1 << 29;
  localparam logic [29:0] M_INCPC = 30'd1 << 27;
  localparam logic [29:0] M_IRI   = 30'd1 << 26;
  localparam logic [29:0] M_MARI  = 30'd1 << 25;
  localparam logic [29:0] M_MDRI  = 30'd1 << 24;
  localparam logic [29:0] M_MDRO  = 30'd1 << 23;
  localparam logic [29:0] M_MRD   = 30'd1 << 22;
  localparam logic [29:0] M_MWR   = 30'd1 << 21;
  localparam logic [29:0] M_RYI   = 30'd1 << 20;
  localparam logic [29:0] M_RZLI  = 30'd1 << 19;
  localparam logic [29:0] M_RZLO  = 30'd1 << 18;
  localparam logic [29:0] M_HIO   = 30'd1 << 15;
  localparam logic [29:0] M_LOO   = 30'd1 << 14;
  localparam logic [29:0] M_IPO   = 30'd1 << 13;
  localparam logic [29:0] M_OPI   = 30'd1 << 12;
  localparam logic [29:0] M_GRA   = 30'd1 << 11;
  localparam logic [29:0] M_GRB   = 30'd1 << 10;
  localparam logic [29:0] M_GRC   = 30'd1 << 9;
  localparam logic [29:0] M_RIN   = 30'd1 << 8;
  localparam logic [29:0] M_ROUT  = 30'd1 << 7;
  localparam logic [29:0] M_BAOUT = 30'd1 << 6;
  localparam logic [29:0] M_CSIGN = 30'd1 << 5;
  localparam logic [29:0] M_RUN   = 30'd1 << 4;

  localparam logic [29:0] F0 = M_PCO | M_MARI | M_INCPC | M_RUN;
  localparam logic [29:0] F1 = M_MRD | M_MDRI | M_RUN;
  localparam logic [29:0] F2 = M_MDRO | M_IRI | M_RUN;

  logic [29:0] obs;
  logic [8:0]  drivers;

  assign obs = {pco, pci, incpc, iri, mari, mdri, mdro, mem_read, mem_write,
                ryi, rzli, rzlo, rzhi, rzho, hio, loo, ipo, opi,
                gra, grb, grc, rin, rout, baout, csigno, run, alu_op};
  assign drivers = {pco, mdro, rzlo, rout, baout, csigno, hio, loo, ipo};

  control_unit #(.OPW(5)) dut (
    .clock(clock), .clear(clear), .ir(ir),
    .pco(pco), .pci(pci), .incpc(incpc), .iri(iri),
    .mari(mari), .mdri(mdri), .mdro(mdro), .mem_read(mem_read), .mem_write(mem_write),
    .ryi(ryi), .rzli(rzli), .rzlo(rzlo), .rzhi(rzhi), .rzho(rzho),
    .hio(hio), .loo(loo), .ipo(ipo), .opi(opi),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .baout(baout), .csigno(csigno), .alu_op(alu_op), .run(run),
    .dbg_state(dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) begin
    checks++;
    if ($countones(drivers) > 1) begin
      errors++;
      $display("FAIL bus_drivers t=%0t: drivers=%b required at most one set", $time, drivers);
    end
  end

  task automatic test_reset();
    clear = 1'b1;
    ir = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== 30'd0 || dbg_state !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h state %0d required 0 state 0", i, obs, dbg_state);
      end
    end
    clear = 1'b0;
    #1;
    checks++;
    if (obs !== 30'd0) begin
      errors++;
      $display("FAIL reset_release: got %h required 0", obs);
    end
    @(negedge clock);
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL reset_first_t0: got %h required %h", obs, F0);
    end
  endtask

  task automatic test_addi();
    logic [29:0] exp_v [0:6];
    ir = 32'h6300_0005;
    exp_v = '{F0, F1, F2, M_GRB | M_ROUT | M_RYI | M_RUN,
              M_CSIGN | M_RZLI | M_RUN, M_RZLO | M_GRA | M_RIN | M_RUN, F0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL addi step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [29:0] exp_v [0:6];
    ir = {5'b00100, 27'h123};
    exp_v = '{F0, F1, F2, M_GRB | M_ROUT | M_RYI | M_RUN,
              M_GRC | M_ROUT | M_RZLI | M_RUN | 30'd1, M_RZLO | M_GRA | M_RIN | M_RUN, F0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL sub step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_or();
    logic [29:0] exp_v [0:6];
    ir = {5'b00110, 27'h0};
    exp_v = '{F0, F1, F2, M_GRB | M_ROUT | M_RYI | M_RUN,
              M_GRC | M_ROUT | M_RZLI | M_RUN | 30'd3, M_RZLO | M_GRA | M_RIN | M_RUN, F0};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL or step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_ld();
    logic [29:0] exp_v [0:8];
    ir = {5'b00000, 27'h7};
    exp_v = '{F0, F1, F2, M_GRB | M_BAOUT | M_RYI | M_RUN, M_CSIGN | M_RZLI | M_RUN,
              M_RZLO | M_MARI | M_RUN, M_MRD | M_MDRI | M_RUN,
              M_MDRO | M_GRA | M_RIN | M_RUN, F0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL ld step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_st();
    logic [29:0] exp_v [0:8];
    ir = {5'b00010, 27'h9};
    exp_v = '{F0, F1, F2, M_GRB | M_BAOUT | M_RYI | M_RUN, M_CSIGN | M_RZLI | M_RUN,
              M_RZLO | M_MARI | M_RUN, M_GRA | M_ROUT | M_MDRI | M_RUN,
              M_MWR | M_RUN, F0};
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL st step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_st_clear();
    logic [29:0] exp_v [0:6];
    logic [29:0] nop_v [0:4];
    ir = {5'b00010, 27'h9};
    exp_v = '{F0, F1, F2, M_GRB | M_BAOUT | M_RYI | M_RUN, M_CSIGN | M_RZLI | M_RUN,
              M_RZLO | M_MARI | M_RUN, M_GRA | M_ROUT | M_MDRI | M_RUN};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL st_clear step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (obs !== 30'd0) begin
      errors++;
      $display("FAIL st_clear_async: got %h required 0", obs);
    end
    ir = {5'b11010, 27'h0};
    @(negedge clock);
    checks++;
    if (obs !== 30'd0) begin
      errors++;
      $display("FAIL st_clear_held: got %h required 0", obs);
    end
    clear = 1'b0;
    nop_v = '{F0, F1, F2, M_RUN, F0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== nop_v[i]) begin
        errors++;
        $display("FAIL st_clear_restart step %0d: got %h required %h", i, obs, nop_v[i]);
      end
    end
  endtask

  task automatic test_single_step();
    logic [4:0]  ops   [0:4];
    logic [29:0] t3_v  [0:4];
    logic [29:0] exp_v [0:4];
    ops  = '{5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010};
    t3_v = '{M_IPO | M_GRA | M_RIN | M_RUN, M_GRA | M_ROUT | M_OPI | M_RUN,
             M_HIO | M_GRA | M_RIN | M_RUN, M_LOO | M_GRA | M_RIN | M_RUN, M_RUN};
    for (int k = 0; k < 5; k++) begin
      ir = {ops[k], 27'h55};
      exp_v = '{F0, F1, F2, t3_v[k], F0};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) @(negedge clock);
        checks++;
        if (obs !== exp_v[i]) begin
          errors++;
          $display("FAIL single_step op %b step %0d: got %h required %h", ops[k], i, obs, exp_v[i]);
        end
      end
    end
  endtask

  task automatic test_undefined();
    logic [29:0] exp_v [0:4];
    ir = 32'hFFFF_FFFF;
    exp_v = '{F0, F1, F2, M_RUN, F0};
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL undefined step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [29:0] exp_v [0:3];
    ir = {5'b11011, 27'h0};
    exp_v = '{F0, F1, F2, M_RUN};
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      checks++;
      if (obs !== exp_v[i]) begin
        errors++;
        $display("FAIL halt step %0d: got %h required %h", i, obs, exp_v[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (obs !== 30'd0 || dbg_state !== 4'd9) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: got %h state %0d required 0 state 9", i, obs, dbg_state);
      end
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    ir = {5'b11010, 27'h0};
    @(negedge clock);
    checks++;
    if (obs !== F0) begin
      errors++;
      $display("FAIL halt_restart: got %h required %h", obs, F0);
    end
  endtask

  initial begin
    clear = 1'b1;
    ir = 32'h0;
    test_reset();
    test_addi();
    test_sub();
    test_or();
    test_ld();
    test_st();
    test_st_clear();
    test_single_step();
    test_undefined();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
